sysid_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its `readdata`. After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), compares both against expected constants, and reports pass/fail to the boot and reset logic. On mismatch it retries a bounded number of times before declaring failure.

---
 rtl/sysid_checker_pkg.sv | 23 ++
 rtl/sysid_checker.sv | 175 +++++++++++++++++
 tb/tb_sysid_checker.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - shared state encoding and word addresses for the system-ID checker
package sysid_checker_pkg;

    // 3-bit state codes, kept as plain constants so other blocks can decode them
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_ID = 3'd1;
    localparam logic [2:0] ST_RD_TS = 3'd2;
    localparam logic [2:0] ST_CMP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RD_ID = ST_RD_ID,
        S_RD_TS = ST_RD_TS,
        S_CMP   = ST_CMP,
        S_DONE  = ST_DONE
    } state_t;

    // Word select on the system-ID slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads system ID and build timestamp, compares them, retries on mismatch
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1339333609,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_RETRY    = 2,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_cnt
);

    localparam logic [3:0] LAT_LAST    = 4'(READ_LATENCY);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_retry_cnt;
    logic        r_auto_armed;
    logic        r_pass;
    logic        r_id_match;
    logic        r_ts_match;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_read;
    logic        w_address;
    logic        w_lat_hit;
    logic        w_id_eq;
    logic        w_ts_eq;
    logic        w_both_eq;
    logic        w_retry_left;
    logic        w_leave_idle;

    assign w_lat_hit    = (r_lat_cnt == LAT_LAST);
    assign w_id_eq      = (r_id_value == EXPECTED_ID);
    assign w_ts_eq      = (r_ts_value == EXPECTED_TS);
    assign w_both_eq    = w_id_eq && w_ts_eq;
    assign w_retry_left = (r_retry_cnt < RETRY_LIMIT);
    assign w_leave_idle = (r_state == S_IDLE) && (w_next_state != S_IDLE);

    // Next-state and bus-strobe decode
    always_comb begin
        w_next_state = r_state;
        w_read       = 1'b0;
        w_address    = SYSID_ADDR_ID;
        case (r_state)
            S_IDLE: begin
                if (start || (AUTO_START && r_auto_armed)) begin
                    w_next_state = S_RD_ID;
                end
            end
            S_RD_ID: begin
                w_read = 1'b1;
                if (w_lat_hit) begin
                    w_next_state = S_RD_TS;
                end
            end
            S_RD_TS: begin
                w_read    = 1'b1;
                w_address = SYSID_ADDR_TS;
                if (w_lat_hit) begin
                    w_next_state = S_CMP;
                end
            end
            S_CMP: begin
                if (w_both_eq || !w_retry_left) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RD_ID;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latency counter restarts on every state change so each read state counts from 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= 4'd0;
        end else if (r_state != w_next_state) begin
            r_lat_cnt <= 4'd0;
        end else if (w_read) begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
        end
    end

    // Auto-start fires once per reset; any exit from IDLE disarms it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_armed <= 1'b1;
        end else if (w_leave_idle) begin
            r_auto_armed <= 1'b0;
        end
    end

    // Capture slave data on the last cycle of each read state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
        end else begin
            if ((r_state == S_RD_ID) && w_lat_hit) begin
                r_id_value <= sysid_readdata;
            end
            if ((r_state == S_RD_TS) && w_lat_hit) begin
                r_ts_value <= sysid_readdata;
            end
        end
    end

    // Compare results, retry bookkeeping and final verdict
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retry_cnt <= 4'd0;
            r_pass      <= 1'b0;
            r_id_match  <= 1'b0;
            r_ts_match  <= 1'b0;
        end else if (w_leave_idle) begin
            r_retry_cnt <= 4'd0;
            r_pass      <= 1'b0;
        end else if (r_state == S_CMP) begin
            r_id_match <= w_id_eq;
            r_ts_match <= w_ts_eq;
            if (!w_both_eq && w_retry_left) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end
            // Verdict is registered on entry to DONE so it is already stable while done is high
            if (w_next_state == S_DONE) begin
                r_pass <= w_both_eq;
            end
        end
    end

    assign sysid_read    = w_read;
    assign sysid_address = w_address;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign id_match      = r_id_match;
    assign ts_match      = r_ts_match;
    assign id_value      = r_id_value;
    assign ts_value      = r_ts_value;
    assign retry_cnt     = r_retry_cnt;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - directed self-checking bench for sysid_checker
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1339333609;
    localparam logic [31:0] BAD    = 32'hDEADBEEF;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: defaults (READ_LATENCY=0, MAX_RETRY=2)
    logic        s0_start = 1'b0;
    logic        s0_addr, s0_read, s0_busy, s0_done, s0_pass, s0_idm, s0_tsm;
    logic [31:0] s0_rdata, s0_idv, s0_tsv;
    logic [3:0]  s0_retry;

    // dut3: READ_LATENCY=3
    logic        s3_start = 1'b0;
    logic        s3_addr, s3_read, s3_busy, s3_done, s3_pass, s3_idm, s3_tsm;
    logic [31:0] s3_rdata, s3_idv, s3_tsv;
    logic [3:0]  s3_retry;

    // dutm: MAX_RETRY=0, slave always returns a wrong ID
    logic        sm_start = 1'b0;
    logic        sm_addr, sm_read, sm_busy, sm_done, sm_pass, sm_idm, sm_tsm;
    logic [31:0] sm_rdata, sm_idv, sm_tsv;
    logic [3:0]  sm_retry;

    sysid_checker dut0 (
        .clock(clock), .reset_n(reset_n), .start(s0_start),
        .sysid_address(s0_addr), .sysid_read(s0_read), .sysid_readdata(s0_rdata),
        .busy(s0_busy), .done(s0_done), .pass(s0_pass), .id_match(s0_idm), .ts_match(s0_tsm),
        .id_value(s0_idv), .ts_value(s0_tsv), .retry_cnt(s0_retry)
    );

    sysid_checker #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .start(s3_start),
        .sysid_address(s3_addr), .sysid_read(s3_read), .sysid_readdata(s3_rdata),
        .busy(s3_busy), .done(s3_done), .pass(s3_pass), .id_match(s3_idm), .ts_match(s3_tsm),
        .id_value(s3_idv), .ts_value(s3_tsv), .retry_cnt(s3_retry)
    );

    sysid_checker #(.MAX_RETRY(0)) dutm (
        .clock(clock), .reset_n(reset_n), .start(sm_start),
        .sysid_address(sm_addr), .sysid_read(sm_read), .sysid_readdata(sm_rdata),
        .busy(sm_busy), .done(sm_done), .pass(sm_pass), .id_match(sm_idm), .ts_match(sm_tsm),
        .id_value(sm_idv), .ts_value(sm_tsv), .retry_cnt(sm_retry)
    );

    // Slave 0: returns a wrong ID for the first bad_id_n ID reads after id_base
    int   id_reads  = 0;
    int   id_base   = 0;
    int   bad_id_n  = 0;
    logic bad_ts    = 1'b0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) id_reads <= 0;
        else if (s0_read && !s0_addr) id_reads <= id_reads + 1;
    end
    assign s0_rdata = s0_addr ? (bad_ts ? BAD : EXP_TS)
                              : ((id_reads - id_base < bad_id_n) ? 32'h1 : EXP_ID);

    // Slave 3: data valid only on the 4th consecutive read cycle at one address
    logic s3_prev_read;
    logic s3_prev_addr;
    int   s3_run;
    int   s3_pos;
    assign s3_pos = (s3_read && s3_prev_read && (s3_prev_addr == s3_addr)) ? s3_run : 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s3_prev_read <= 1'b0;
            s3_prev_addr <= 1'b0;
            s3_run       <= 0;
        end else begin
            s3_prev_read <= s3_read;
            s3_prev_addr <= s3_addr;
            s3_run       <= s3_pos + 1;
        end
    end
    assign s3_rdata = (s3_read && s3_pos == 3) ? (s3_addr ? EXP_TS : EXP_ID) : BAD;

    assign sm_rdata = sm_addr ? EXP_TS : 32'h1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts edges from the one that samples start until done is seen high
    task automatic wait_done0(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clock);
            cyc++;
            #1;
            s0_start = 1'b0;
        end while (!s0_done && cyc < limit);
    endtask

    typedef struct {
        int          bad_id_n;
        logic        bad_ts;
        int          exp_cyc;
        logic        exp_pass;
        logic        exp_idm;
        logic        exp_tsm;
        logic [3:0]  exp_retry;
        int          exp_idreads;
        logic [31:0] exp_idv;
        logic [31:0] exp_tsv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int d0, d3, dm;

        vecs[0] = '{0, 1'b0,  4, 1'b1, 1'b1, 1'b1, 4'd0, 1, EXP_ID, EXP_TS};
        vecs[1] = '{1, 1'b0,  7, 1'b1, 1'b1, 1'b1, 4'd1, 2, EXP_ID, EXP_TS};
        vecs[2] = '{2, 1'b0, 10, 1'b1, 1'b1, 1'b1, 4'd2, 3, EXP_ID, EXP_TS};
        vecs[3] = '{3, 1'b0, 10, 1'b0, 1'b0, 1'b1, 4'd2, 3, 32'h1,  EXP_TS};
        vecs[4] = '{0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 4'd2, 3, EXP_ID, BAD};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_flags", {29'd0, s0_busy, s0_done, s0_pass}, 32'd0);
        check("rst_bus", {30'd0, s0_read, s0_addr}, 32'd0);
        check("rst_match", {28'd0, s0_idm, s0_tsm, s0_retry != 4'd0, 1'b0}, 32'd0);
        check("rst_idv", s0_idv, 32'd0);
        check("rst_tsv", s0_tsv, 32'd0);

        // Auto-start after reset release on all three instances
        @(negedge clock);
        reset_n = 1'b1;
        d0 = 0; d3 = 0; dm = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock);
            #1;
            if (s0_done && d0 == 0) d0 = c;
            if (s3_done && d3 == 0) d3 = c;
            if (sm_done && dm == 0) dm = c;
        end
        check("auto_done_cyc", d0, 4);
        check("auto_pass", {31'd0, s0_pass}, 32'd1);
        check("auto_retry", {28'd0, s0_retry}, 32'd0);
        check("auto_tsv", s0_tsv, EXP_TS);
        check("auto_idv", s0_idv, EXP_ID);
        check("auto_l3_done_cyc", d3, 10);
        check("auto_l3_pass", {31'd0, s3_pass}, 32'd1);
        check("auto_l3_tsv", s3_tsv, EXP_TS);
        check("m0_done_cyc", dm, 4);
        check("m0_pass", {31'd0, sm_pass}, 32'd0);
        check("m0_idm", {31'd0, sm_idm}, 32'd0);
        check("m0_retry", {28'd0, sm_retry}, 32'd0);
        check("idle_busy", {31'd0, s0_busy}, 32'd0);

        // Table of single-start checks on dut0
        for (int i = 0; i < 5; i++) begin
            bad_id_n = vecs[i].bad_id_n;
            bad_ts   = vecs[i].bad_ts;
            id_base  = id_reads;
            s0_start = 1'b1;
            wait_done0(40, cyc);
            check($sformatf("v%0d_done_cyc", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_pass", i), {31'd0, s0_pass}, {31'd0, vecs[i].exp_pass});
            check($sformatf("v%0d_idm", i), {31'd0, s0_idm}, {31'd0, vecs[i].exp_idm});
            check($sformatf("v%0d_tsm", i), {31'd0, s0_tsm}, {31'd0, vecs[i].exp_tsm});
            check($sformatf("v%0d_retry", i), {28'd0, s0_retry}, {28'd0, vecs[i].exp_retry});
            check($sformatf("v%0d_passes", i), id_reads - id_base, vecs[i].exp_idreads);
            check($sformatf("v%0d_idv", i), s0_idv, vecs[i].exp_idv);
            check($sformatf("v%0d_tsv", i), s0_tsv, vecs[i].exp_tsv);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_hold_pass", i), {31'd0, s0_pass}, {31'd0, vecs[i].exp_pass});
        end
        bad_id_n = 0;
        bad_ts   = 1'b0;

        // READ_LATENCY=3 started by pulse
        s3_start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clock);
            cyc++;
            #1;
            s3_start = 1'b0;
        end while (!s3_done && cyc < 40);
        check("l3_done_cyc", cyc, 10);
        check("l3_pass", {31'd0, s3_pass}, 32'd1);
        check("l3_idv", s3_idv, EXP_ID);
        check("l3_tsv", s3_tsv, EXP_TS);
        check("l3_retry", {28'd0, s3_retry}, 32'd0);

        // start held for 20 cycles: back-to-back passes, one IDLE cycle between them
        id_base  = id_reads;
        s0_start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clock);
            #1;
            check($sformatf("held_busy_e%0d", e), {31'd0, s0_busy}, {31'd0, (e % 5) != 0});
            check($sformatf("held_done_e%0d", e), {31'd0, s0_done}, {31'd0, (e % 5) == 4});
        end
        s0_start = 1'b0;
        check("held_passes", id_reads - id_base, 4);

        // Reset asserted while reading the timestamp
        s0_start = 1'b1;
        @(posedge clock);
        #1;
        s0_start = 1'b0;
        @(posedge clock);
        #1;
        check("mid_in_rd_ts", {30'd0, s0_read, s0_addr}, 32'd3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_flags", {27'd0, s0_busy, s0_done, s0_pass, s0_idm, s0_tsm}, 32'd0);
        check("mid_rst_bus", {30'd0, s0_read, s0_addr}, 32'd0);
        check("mid_rst_retry", {28'd0, s0_retry}, 32'd0);
        check("mid_rst_idv", s0_idv, 32'd0);
        check("mid_rst_tsv", s0_tsv, 32'd0);
        id_base = 0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_done0(40, cyc);
        check("rearm_done_cyc", cyc, 4);
        check("rearm_pass", {31'd0, s0_pass}, 32'd1);
        check("rearm_retry", {28'd0, s0_retry}, 32'd0);

        repeat (20) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
